// File: rtl/yu_mux_pkg.sv
// rtl/yu_mux_pkg.sv - shared mode constants and width helper for the registered N-input mux
package yu_mux_pkg;

    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;

    // Keeps select/source ports at least one bit wide even for degenerate N.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_reg_rr_arbiter.sv
// rtl/mux_n_reg_rr_arbiter.sv - combinational rotate-priority encoder starting after ptr
module rr_arbiter
    import yu_mux_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_valid
);

    int idx;

    // Scan farthest-first so the nearest requester after ptr is the last one written.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = N; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx[SEL_W-1:0]]) begin
                grant_idx   = idx[SEL_W-1:0];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_reg.sv
// rtl/mux_n_reg.sv - N-input valid/ready mux with one output register; MUX_N_REG_LOCK_EN adds packet lock
module mux_n_reg
    import yu_mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    parameter  int MODE  = MUX_MODE_SEL,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
`ifdef MUX_N_REG_LOCK_EN
    input  logic [N-1:0]       in_last,
    output logic               out_last,
`endif
    input  logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_src
);

    logic             load_en;
    logic             base_valid;
    logic             grant_valid;
    logic             xfer;
    logic [SEL_W-1:0] base_idx;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] sel_data;

    assign load_en = !out_valid || out_ready;

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            logic [SEL_W-1:0] rr_ptr;

            rr_arbiter #(.N(N)) u_arb (
                .req        (in_valid),
                .ptr        (rr_ptr),
                .grant_idx  (base_idx),
                .grant_valid(base_valid)
            );

            // Reset to N-1 so the first search after reset starts at channel 0.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rr_ptr <= SEL_W'(N - 1);
                end else if (xfer) begin
                    rr_ptr <= grant;
                end
            end
        end else begin : g_sel
            assign base_idx   = sel;
            assign base_valid = (int'(sel) < N);
        end
    endgenerate

`ifdef MUX_N_REG_LOCK_EN
    logic             locked;
    logic [SEL_W-1:0] lock_idx;
    logic             sel_last;

    assign grant       = locked ? lock_idx : base_idx;
    assign grant_valid = locked || base_valid;
`else
    assign grant       = base_idx;
    assign grant_valid = base_valid;
`endif

    always_comb begin
        in_ready = '0;
        xfer     = 1'b0;
        sel_data = '0;
`ifdef MUX_N_REG_LOCK_EN
        sel_last = 1'b1;
`endif
        for (int i = 0; i < N; i++) begin
            if (load_en && grant_valid && (grant == SEL_W'(i))) begin
                in_ready[i] = 1'b1;
                xfer        = in_valid[i];
                sel_data    = in_data[i*WIDTH +: WIDTH];
`ifdef MUX_N_REG_LOCK_EN
                sel_last    = in_last[i];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
`ifdef MUX_N_REG_LOCK_EN
            out_last  <= 1'b0;
            locked    <= 1'b0;
            lock_idx  <= '0;
`endif
        end else if (load_en) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= sel_data;
                out_src  <= grant;
`ifdef MUX_N_REG_LOCK_EN
                out_last <= sel_last;
                locked   <= !sel_last;
                lock_idx <= grant;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mux_n_reg.sv
// tb/tb_mux_n_reg.sv - scoreboard bench for mux_n_reg in select (N=4, N=6) and round-robin (N=3) builds
module tb_mux_n_reg;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  src;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    beat_t q0[$];
    beat_t q6[$];
    beat_t q3[$];

    logic [3:0]   v0, r0;
    logic [127:0] data0;
    logic [1:0]   sel0, os0;
    logic         ov0, ordy0, ol0;
    logic [31:0]  od0;
    logic [3:0]   l0;

    logic [5:0]   v6, r6;
    logic [191:0] data6;
    logic [2:0]   sel6, os6;
    logic         ov6, ordy6, ol6;
    logic [31:0]  od6;
    logic [5:0]   l6;

    logic [2:0]   v3, r3;
    logic [95:0]  data3;
    logic [1:0]   sel3, os3;
    logic         ov3, ordy3, ol3;
    logic [31:0]  od3;
    logic [2:0]   l3;

    mux_n_reg #(.WIDTH(32), .N(4), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0), .in_data(data0),
`ifdef MUX_N_REG_LOCK_EN
        .in_last(l0), .out_last(ol0),
`endif
        .sel(sel0), .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .out_src(os0)
    );

    mux_n_reg #(.WIDTH(32), .N(6), .MODE(0)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(r6), .in_data(data6),
`ifdef MUX_N_REG_LOCK_EN
        .in_last(l6), .out_last(ol6),
`endif
        .sel(sel6), .out_valid(ov6), .out_ready(ordy6), .out_data(od6), .out_src(os6)
    );

    mux_n_reg #(.WIDTH(32), .N(3), .MODE(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(r3), .in_data(data3),
`ifdef MUX_N_REG_LOCK_EN
        .in_last(l3), .out_last(ol3),
`endif
        .sel(sel3), .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .out_src(os3)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input int which, input logic [31:0] d, input int s, input logic l);
        beat_t b;
        b.data = d;
        b.src  = 4'(s);
        b.last = l;
        case (which)
            0:       q0.push_back(b);
            6:       q6.push_back(b);
            default: q3.push_back(b);
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        beat_t b;
        if (rst_n && ov0 && ordy0) begin
            if (q0.size() == 0) check_eq("d0_unexpected_beat", 32'(q0.size()), 32'd1);
            else begin
                b = q0.pop_front();
                check_eq("d0_data", od0, b.data);
                check_eq("d0_src", 32'(os0), 32'(b.src));
`ifdef MUX_N_REG_LOCK_EN
                check_eq("d0_last", 32'(ol0), 32'(b.last));
`endif
            end
        end
    end

    always @(negedge clk) begin
        beat_t b;
        if (rst_n && ov6 && ordy6) begin
            if (q6.size() == 0) check_eq("d6_unexpected_beat", 32'(q6.size()), 32'd1);
            else begin
                b = q6.pop_front();
                check_eq("d6_data", od6, b.data);
                check_eq("d6_src", 32'(os6), 32'(b.src));
`ifdef MUX_N_REG_LOCK_EN
                check_eq("d6_last", 32'(ol6), 32'(b.last));
`endif
            end
        end
    end

    always @(negedge clk) begin
        beat_t b;
        if (rst_n && ov3 && ordy3) begin
            if (q3.size() == 0) check_eq("d3_unexpected_beat", 32'(q3.size()), 32'd1);
            else begin
                b = q3.pop_front();
                check_eq("d3_data", od3, b.data);
                check_eq("d3_src", 32'(os3), 32'(b.src));
`ifdef MUX_N_REG_LOCK_EN
                check_eq("d3_last", 32'(ol3), 32'(b.last));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ks[4];
        ks = '{0, 1, 3, 2};
        rst_n = 1'b0;
        v0 = '0; v6 = '0; v3 = '0;
        sel0 = '0; sel6 = '0; sel3 = '0;
        ordy0 = 1'b1; ordy6 = 1'b1; ordy3 = 1'b1;
        l0 = '1; l6 = '1; l3 = '1;
        for (int i = 0; i < 4; i++) data0[i*32 +: 32] = 32'h11 * i;
        for (int i = 0; i < 6; i++) data6[i*32 +: 32] = 32'h60 + i;
        for (int i = 0; i < 3; i++) data3[i*32 +: 32] = 32'h30 + i;

        #3;
        check_eq("rst_ov0", 32'(ov0), 32'd0);
        check_eq("rst_od0", od0, 32'd0);
        check_eq("rst_os0", 32'(os0), 32'd0);
        check_eq("rst_ov3", 32'(ov3), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // select mode, single beat from channel 2
        step();
        sel0 = 2'd2; v0 = 4'hf;
        #1 check_eq("d0_ready_sel2", 32'(r0), 32'h4);
        push(0, 32'h22, 2, 1'b1);
        step();
        v0 = '0;
        #1 check_eq("d0_latency", 32'(ov0), 32'd1);
        step();
        check_eq("d0_drop", 32'(ov0), 32'd0);

        // back-to-back select changes at full throughput
        for (int k = 0; k < 4; k++) begin
            step();
            if (k > 0) check_eq("d0_stream_valid", 32'(ov0), 32'd1);
            sel0 = 2'(ks[k]); v0 = 4'hf;
            #1 check_eq("d0_stream_ready", 32'(r0), 32'(1 << ks[k]));
            push(0, 32'h11 * ks[k], ks[k], 1'b1);
        end
        step();
        v0 = '0;
        check_eq("d0_stream_tail", 32'(ov0), 32'd1);
        step();
        check_eq("d0_stream_drop", 32'(ov0), 32'd0);

        // N=6: top valid index, then an out-of-range select
        step();
        sel6 = 3'd5; v6 = 6'h3f;
        #1 check_eq("d6_ready_sel5", 32'(r6), 32'h20);
        push(6, 32'h65, 5, 1'b1);
        step();
        sel6 = 3'd7;
        #1 check_eq("d6_ready_sel7", 32'(r6), 32'h0);
        check_eq("d6_held", 32'(ov6), 32'd1);
        step();
        v6 = '0;
        #1 check_eq("d6_drain", 32'(ov6), 32'd0);

        // round-robin, all requesting, then a sparse pattern that wraps
        for (int c = 0; c < 6; c++) begin
            step();
            if (c > 0) check_eq("d3_rr_valid", 32'(ov3), 32'd1);
            v3 = 3'b111;
            #1 check_eq("d3_rr_ready", 32'(r3), 32'(1 << (c % 3)));
            push(3, 32'h30 + (c % 3), c % 3, 1'b1);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            check_eq("d3_sparse_valid", 32'(ov3), 32'd1);
            v3 = 3'b101;
            #1 check_eq("d3_sparse_ready", 32'(r3), 32'((c % 2 == 1) ? 4 : 1));
            push(3, 32'h30 + ((c % 2 == 1) ? 2 : 0), (c % 2 == 1) ? 2 : 0, 1'b1);
        end
        step();
        v3 = '0;
        check_eq("d3_tail", 32'(ov3), 32'd1);
        step();
        check_eq("d3_drop", 32'(ov3), 32'd0);

        // backpressure: stall three cycles, then drain and load on the same edge
        step();
        sel0 = 2'd1; v0 = 4'hf;
        #1 check_eq("bp_ready_first", 32'(r0), 32'h2);
        push(0, 32'h11, 1, 1'b1);
        step();
        ordy0 = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) step();
            sel0 = 2'(s + 2);
            #1 check_eq("bp_ready_stall", 32'(r0), 32'h0);
            check_eq("bp_data_hold", od0, 32'h11);
            check_eq("bp_src_hold", 32'(os0), 32'd1);
        end
        step();
        ordy0 = 1'b1; sel0 = 2'd3;
        #1 check_eq("bp_ready_release", 32'(r0), 32'h8);
        push(0, 32'h33, 3, 1'b1);
        step();
        v0 = '0;
        check_eq("bp_no_bubble", 32'(ov0), 32'd1);
        step();
        check_eq("bp_drop", 32'(ov0), 32'd0);

`ifdef MUX_N_REG_LOCK_EN
        // packet lock: channel 1 keeps the grant over channel 0 until its last beat
        step();
        v3 = 3'b010; l3 = 3'b000; data3[32 +: 32] = 32'hA0;
        #1 check_eq("lock_ready_0", 32'(r3), 32'h2);
        push(3, 32'hA0, 1, 1'b0);
        step();
        v3 = 3'b011; data3[32 +: 32] = 32'hA1;
        #1 check_eq("lock_ready_1", 32'(r3), 32'h2);
        push(3, 32'hA1, 1, 1'b0);
        step();
        l3 = 3'b010; data3[32 +: 32] = 32'hA2;
        #1 check_eq("lock_ready_2", 32'(r3), 32'h2);
        push(3, 32'hA2, 1, 1'b1);
        step();
        v3 = 3'b001; l3 = 3'b111;
        #1 check_eq("lock_release", 32'(r3), 32'h1);
        push(3, 32'h30, 0, 1'b1);
        step();
        v3 = '0;
        check_eq("lock_tail", 32'(ov3), 32'd1);
        step();
        check_eq("lock_drop", 32'(ov3), 32'd0);
`endif

        // reset while stalled discards the held beat
        step();
        data0[31:0] = 32'hDEADBEEF; sel0 = 2'd0; v0 = 4'hf; ordy0 = 1'b1;
        push(0, 32'hDEADBEEF, 0, 1'b1);
        step();
        v0 = '0; ordy0 = 1'b0;
        #1 check_eq("mid_rst_held", od0, 32'hDEADBEEF);
        #1 rst_n = 1'b0;
        #1 check_eq("mid_rst_ov0", 32'(ov0), 32'd0);
        check_eq("mid_rst_od0", od0, 32'd0);
        check_eq("mid_rst_os0", 32'(os0), 32'd0);
        q0.delete();
        step();
        step();
        rst_n = 1'b1; ordy0 = 1'b1;
        step();
        v3 = 3'b111;
        #1 check_eq("post_rst_rr_first", 32'(r3), 32'h1);
        push(3, 32'h30, 0, 1'b1);
        step();
        v3 = '0;
        check_eq("post_rst_valid", 32'(ov3), 32'd1);
        step();
        check_eq("post_rst_drop", 32'(ov3), 32'd0);

        check_eq("q0_empty", 32'(q0.size()), 32'd0);
        check_eq("q6_empty", 32'(q6.size()), 32'd0);
        check_eq("q3_empty", 32'(q3.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
